// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the PCIE transmit aggregator.
// Contents: lane count, lane ID type and FSM state encoding.
package pcie_tx_pkg;

    localparam int unsigned N_LANES = 4;
    localparam int unsigned LANE_W  = 2;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        StReset  = 2'd0,
        StInit   = 2'd1,
        StIdle   = 2'd2,
        StActive = 2'd3
    } estado_t;

endpackage

// File: rtl/arbitro_tx_rr_if.sv
// Bus bundle for arbitro_tx_rr: source FIFO read side, downstream push side and
// the per-lane counter read port.
//   master: the aggregator (drives pop, push_out, data_out, cuenta, valid_cuenta)
//   slave : the surrounding FIFOs / requester
interface arbitro_tx_rr_if
    import pcie_tx_pkg::*;
#(
    parameter int unsigned TAMANO_DATOS = 12,
    parameter int unsigned UMBRALES_L_H = 8,
    parameter int unsigned CONT_W       = 5
);
    logic [N_LANES-1:0]      empty_in;
    logic [TAMANO_DATOS-1:0] data_in0;
    logic [TAMANO_DATOS-1:0] data_in1;
    logic [TAMANO_DATOS-1:0] data_in2;
    logic [TAMANO_DATOS-1:0] data_in3;
    logic [N_LANES-1:0]      pop;
    logic [UMBRALES_L_H-1:0] ocup_out;
    logic                    push_out;
    logic [TAMANO_DATOS-1:0] data_out;
    logic                    req;
    logic [2:0]              idx;
    logic [CONT_W-1:0]       cuenta;
    logic                    valid_cuenta;

    modport master (
        input  empty_in, data_in0, data_in1, data_in2, data_in3, ocup_out, req, idx,
        output pop, push_out, data_out, cuenta, valid_cuenta
    );

    modport slave (
        output empty_in, data_in0, data_in1, data_in2, data_in3, ocup_out, req, idx,
        input  pop, push_out, data_out, cuenta, valid_cuenta
    );

endinterface

// File: rtl/rr_arbitro.sv
// Lane arbiter for arbitro_tx_rr.
// Default build: round-robin, grants the first non-empty lane after the pointer
// (wrapping 3 -> 0); the pointer moves to the granted lane when avanza=1.
// With PRIO_FIJA_EN defined: fixed priority (lane 0 highest), no pointer state.
// Ports: clk, reset (async active-low), avanza (grant consumed; RR build only),
//        empty_in (per-lane empty), grant (one-hot), grant_idx, hay_grant.
module rr_arbitro
    import pcie_tx_pkg::*;
(
`ifndef PRIO_FIJA_EN
    input  logic               clk,
    input  logic               reset,
    input  logic               avanza,
`endif
    input  logic [N_LANES-1:0] empty_in,
    output logic [N_LANES-1:0] grant,
    output lane_t              grant_idx,
    output logic               hay_grant
);

`ifdef PRIO_FIJA_EN

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hay_grant = 1'b0;
        // Descending scan: the lowest non-empty lane is the last to write.
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (!empty_in[i]) begin
                hay_grant = 1'b1;
                grant_idx = lane_t'(i);
            end
        end
        if (hay_grant) grant[grant_idx] = 1'b1;
    end

`else

    lane_t ptr_q;
    lane_t cand;

    always_comb begin
        grant     = '0;
        grant_idx = ptr_q;
        hay_grant = 1'b0;
        cand      = ptr_q;
        // Offset N_LANES wraps to the pointer itself (lowest priority); offset 1 wins last.
        for (int i = N_LANES; i >= 1; i--) begin
            cand = ptr_q + lane_t'(i);
            if (!empty_in[cand]) begin
                hay_grant = 1'b1;
                grant_idx = cand;
            end
        end
        if (hay_grant) grant[grant_idx] = 1'b1;
    end

    // Reset value 3 makes lane 0 the first winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= lane_t'(N_LANES - 1);
        end else if (avanza) begin
            ptr_q <= grant_idx;
        end
    end

`endif

endmodule

// File: rtl/arbitro_tx_rr.sv
// Transmit-side aggregator: drains four source FIFOs through an arbiter into one
// push stream, with hysteresis flow control and per-lane word counters.
// Optional macro PRIO_FIJA_EN: fixed-priority arbitration instead of round-robin.
// Ports: clk, reset (async active-low), init (config mode, latches thresholds),
//        umbral_L/umbral_H (resume/pause thresholds), bus (arbitro_tx_rr_if.master:
//        empty_in, data_in0..3, pop, ocup_out, push_out, data_out, req, idx,
//        cuenta, valid_cuenta).
module arbitro_tx_rr
    import pcie_tx_pkg::*;
#(
    parameter int unsigned TAMANO_DATOS = 12,
    parameter int unsigned UMBRALES_L_H = 8,
    parameter int unsigned CONT_W       = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRALES_L_H-1:0] umbral_L,
    input  logic [UMBRALES_L_H-1:0] umbral_H,
    arbitro_tx_rr_if.master         bus
);

    estado_t                 estado_q;
    logic [UMBRALES_L_H-1:0] umbral_l_q;
    logic [UMBRALES_L_H-1:0] umbral_h_q;
    logic                    pausa_q;

    logic [N_LANES-1:0]      grant;
    lane_t                   grant_idx;
    logic                    hay_grant;
    logic                    pop_en;
    logic                    avanza;

    logic                    vuelo_q;       // a word was popped last cycle
    lane_t                   vuelo_lane_q;
    logic                    push_q;
    logic [TAMANO_DATOS-1:0] data_out_q;
    logic [TAMANO_DATOS-1:0] dato_sel;
    logic [CONT_W-1:0]       contador_q [N_LANES];
    logic [CONT_W-1:0]       cuenta_q;
    logic                    valid_cuenta_q;

    rr_arbitro u_arb (
`ifndef PRIO_FIJA_EN
        .clk       (clk),
        .reset     (reset),
        .avanza    (avanza),
`endif
        .empty_in  (bus.empty_in),
        .grant     (grant),
        .grant_idx (grant_idx),
        .hay_grant (hay_grant)
    );

    assign pop_en  = (estado_q == StActive) && !pausa_q && !init;
    assign avanza  = pop_en && hay_grant;
    assign bus.pop = pop_en ? grant : '0;

    // FSM, threshold latch and hysteresis flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= StReset;
            umbral_l_q <= '0;
            umbral_h_q <= '0;
            pausa_q    <= 1'b0;
        end else begin
            // Set wins when the thresholds overlap.
            if (bus.ocup_out >= umbral_h_q) begin
                pausa_q <= 1'b1;
            end else if (bus.ocup_out <= umbral_l_q) begin
                pausa_q <= 1'b0;
            end

            if ((estado_q == StInit) && init) begin
                umbral_l_q <= umbral_L;
                umbral_h_q <= umbral_H;
            end

            if (init) begin
                estado_q <= StInit;
            end else begin
                unique case (estado_q)
                    StReset:  estado_q <= StInit;
                    StInit:   estado_q <= StIdle;
                    StIdle:   if ((bus.empty_in != '1) && !pausa_q) estado_q <= StActive;
                    StActive: if ((bus.empty_in == '1) || pausa_q) estado_q <= StIdle;
                    default:  estado_q <= StReset;
                endcase
            end
        end
    end

    always_comb begin
        dato_sel = bus.data_in0;
        case (vuelo_lane_q)
            2'd0:    dato_sel = bus.data_in0;
            2'd1:    dato_sel = bus.data_in1;
            2'd2:    dato_sel = bus.data_in2;
            default: dato_sel = bus.data_in3;
        endcase
    end

    // Pop -> sample -> push pipeline, counters and counter read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vuelo_q        <= 1'b0;
            vuelo_lane_q   <= '0;
            push_q         <= 1'b0;
            data_out_q     <= '0;
            cuenta_q       <= '0;
            valid_cuenta_q <= 1'b0;
            for (int i = 0; i < N_LANES; i++) contador_q[i] <= '0;
        end else begin
            vuelo_q <= avanza;
            if (avanza) vuelo_lane_q <= grant_idx;
            push_q <= vuelo_q;
            if (vuelo_q) begin
                data_out_q                 <= dato_sel;
                contador_q[vuelo_lane_q]   <= contador_q[vuelo_lane_q] + CONT_W'(1);
            end
            // Reads see the pre-increment value when a push lands on the same edge.
            valid_cuenta_q <= bus.req;
            cuenta_q       <= '0;
            if (bus.req && !bus.idx[2]) cuenta_q <= contador_q[bus.idx[1:0]];
        end
    end

    assign bus.push_out     = push_q;
    assign bus.data_out     = data_out_q;
    assign bus.cuenta       = cuenta_q;
    assign bus.valid_cuenta = valid_cuenta_q;

endmodule

// File: tb/tb_arbitro_tx_rr.sv
module tb_arbitro_tx_rr;

    typedef logic [11:0] word_t;

    typedef struct {
        logic       req;
        logic [2:0] idx;
        logic       exp_valid;
        logic [4:0] exp_cuenta;
    } rd_vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       init = 1'b0;
    logic [7:0] umbral_L = '0;
    logic [7:0] umbral_H = '0;

    int n_checks = 0;
    int n_fail   = 0;

    arbitro_tx_rr_if bus ();

    arbitro_tx_rr dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .umbral_L (umbral_L),
        .umbral_H (umbral_H),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Source FIFO models: registered read data, empty updated on the pop edge.
    word_t mem [4][256];
    int    head [4] = '{0, 0, 0, 0};
    int    tail [4] = '{0, 0, 0, 0};
    word_t data_r [4];
    logic  flush = 1'b0;

    assign bus.data_in0 = data_r[0];
    assign bus.data_in1 = data_r[1];
    assign bus.data_in2 = data_r[2];
    assign bus.data_in3 = data_r[3];

    always @(posedge clk) begin
        int h;
        logic [3:0] e;
        for (int k = 0; k < 4; k++) begin
            h = head[k];
            if (flush) begin
                h = tail[k];
            end else if (bus.pop[k] && (h != tail[k])) begin
                data_r[k] <= mem[k][h];
                h = h + 1;
            end
            head[k] <= h;
            e[k] = (h == tail[k]);
        end
        bus.empty_in <= e;
    end

    // Monitor, sampled away from the active edge.
    int    cyc = 0;
    int    multi_pop = 0;
    int    pop_log[$];
    int    pop_cyc[$];
    word_t push_log[$];
    int    push_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.pop != 4'b0) begin
            if ($countones(bus.pop) != 1) multi_pop++;
            for (int k = 0; k < 4; k++) begin
                if (bus.pop[k]) begin
                    pop_log.push_back(k);
                    pop_cyc.push_back(cyc);
                end
            end
        end
        if (bus.push_out) begin
            push_log.push_back(bus.data_out);
            push_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input int n, input int base);
        for (int s = 0; s < n; s++) begin
            mem[k][tail[k]] = word_t'(k * 256 + base + s);
            tail[k] = tail[k] + 1;
        end
    endtask

    task automatic do_init();
        init     = 1'b1;
        umbral_L = 8'd2;
        umbral_H = 8'd6;
        repeat (3) tick();
        init = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_push(input int target, input int budget, input string name);
        int n = 0;
        while ((push_log.size() < target) && (n < budget)) begin
            tick();
            n++;
        end
        chk(name, int'(push_log.size() >= target), 1);
    endtask

    task automatic wait_pop(input int budget, input string name);
        int n = 0;
        while ((bus.pop == 4'b0) && (n < budget)) begin
            tick();
            n++;
        end
        chk(name, int'(bus.pop != 4'b0), 1);
    endtask

    function automatic int pop_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 99;
    endfunction

    function automatic int push_at(input int i);
        return (i < push_log.size()) ? int'(push_log[i]) : -1;
    endfunction

    rd_vec_t rd_tab [8];

    task automatic run_reads(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.req = rd_tab[i].req;
            bus.idx = rd_tab[i].idx;
            tick();
            chk($sformatf("%s valid[%0d]", tag, i), bus.valid_cuenta, rd_tab[i].exp_valid);
            if (rd_tab[i].exp_valid)
                chk($sformatf("%s cuenta idx%0d", tag, rd_tab[i].idx), bus.cuenta,
                    rd_tab[i].exp_cuenta);
        end
        bus.req = 1'b0;
        bus.idx = '0;
    endtask

    int exp_order [8];
    int pb, qb, np0, nq0;

    initial begin
        bus.ocup_out = '0;
        bus.req      = 1'b0;
        bus.idx      = '0;

        // Reset state
        repeat (3) tick();
        chk("rst pop", bus.pop, 0);
        chk("rst push_out", bus.push_out, 0);
        chk("rst data_out", bus.data_out, 0);
        chk("rst cuenta", bus.cuenta, 0);
        chk("rst valid_cuenta", bus.valid_cuenta, 0);
        reset = 1'b1;
        do_init();

        // T1: all lanes 2 words -> round-robin 0,1,2,3,0,1,2,3
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        pb = pop_log.size();
        qb = push_log.size();
        for (int k = 0; k < 4; k++) load(k, 2, 0);
        wait_push(qb + 8, 40, "t1 eight pushes");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1 pop order %0d", i), pop_at(pb + i), exp_order[i]);
            chk($sformatf("t1 data %0d", i), push_at(qb + i), (i % 4) * 256 + i / 4);
        end
        chk("t1 latency", push_cyc[qb] - pop_cyc[pb], 2);
        rd_tab[0] = '{1'b1, 3'd0, 1'b1, 5'd2};
        rd_tab[1] = '{1'b1, 3'd1, 1'b1, 5'd2};
        rd_tab[2] = '{1'b1, 3'd2, 1'b1, 5'd2};
        rd_tab[3] = '{1'b1, 3'd3, 1'b1, 5'd2};
        rd_tab[4] = '{1'b1, 3'd5, 1'b1, 5'd0};
        rd_tab[5] = '{1'b0, 3'd0, 1'b0, 5'd0};
        run_reads(6, "t1");

        // T2: only lane 2, 5 consecutive pops
        pb = pop_log.size();
        qb = push_log.size();
        load(2, 5, 16);
        wait_push(qb + 5, 30, "t2 five pushes");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2 pop lane %0d", i), pop_at(pb + i), 2);
            chk($sformatf("t2 data %0d", i), push_at(qb + i), 2 * 256 + 16 + i);
        end
        chk("t2 back-to-back", pop_cyc[pb + 4] - pop_cyc[pb], 4);

        // T3: hysteresis pause / resume
        pb = pop_log.size();
        qb = push_log.size();
        load(0, 10, 64);
        wait_pop(10, "t3 stream start");
        repeat (2) tick();
        bus.ocup_out = 8'd6;
        np0 = pop_log.size();
        nq0 = push_log.size();
        repeat (5) tick();
        chk("t3 pops after pause <=1", int'(pop_log.size() - np0 <= 1), 1);
        chk("t3 pushes after pause <=3", int'(push_log.size() - nq0 <= 3), 1);
        chk("t3 pop held", bus.pop, 0);
        bus.ocup_out = 8'd3;
        np0 = pop_log.size();
        repeat (4) tick();
        chk("t3 still paused at 3", pop_log.size() - np0, 0);
        bus.ocup_out = 8'd2;
        wait_pop(6, "t3 resume at 2");
        wait_push(qb + 10, 40, "t3 ten pushes");
        for (int i = 0; i < 10; i++)
            chk($sformatf("t3 data %0d", i), push_at(qb + i), 64 + i);
        bus.ocup_out = 8'd0;

        // T4: reset with words in flight
        load(1, 4, 96);
        wait_pop(10, "t4 stream start");
        repeat (2) tick();
        chk("t4 push before reset", bus.push_out, 1);
        reset = 1'b0;
        #1;
        chk("t4 push_out cleared", bus.push_out, 0);
        chk("t4 pop cleared", bus.pop, 0);
        chk("t4 data_out cleared", bus.data_out, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        reset = 1'b1;
        do_init();
        rd_tab[0] = '{1'b1, 3'd0, 1'b1, 5'd0};
        rd_tab[1] = '{1'b1, 3'd1, 1'b1, 5'd0};
        rd_tab[2] = '{1'b1, 3'd2, 1'b1, 5'd0};
        rd_tab[3] = '{1'b1, 3'd3, 1'b1, 5'd0};
        run_reads(4, "t4");
        qb = push_log.size();
        for (int k = 0; k < 4; k++) load(k, 1, 112);
        wait_pop(10, "t4 restart");
        chk("t4 lane 0 first", bus.pop, 1);
        wait_push(qb + 4, 20, "t4 four pushes");

        // T5: 33 words on lane 1 -> counter wraps to 1
        reset = 1'b0;
        tick();
        reset = 1'b1;
        do_init();
        qb = push_log.size();
        load(1, 33, 128);
        wait_push(qb + 33, 80, "t5 33 pushes");
        rd_tab[0] = '{1'b1, 3'd1, 1'b1, 5'd1};
        rd_tab[1] = '{1'b1, 3'd5, 1'b1, 5'd0};
        rd_tab[2] = '{1'b1, 3'd0, 1'b1, 5'd0};
        rd_tab[3] = '{1'b1, 3'd7, 1'b1, 5'd0};
        rd_tab[4] = '{1'b0, 3'd1, 1'b0, 5'd0};
        run_reads(5, "t5");

        // T6: lanes 0 and 3 contend (pointer sits at lane 1)
`ifdef PRIO_FIJA_EN
        exp_order = '{0, 0, 0, 3, 3, 3, 0, 0};
`else
        exp_order = '{3, 0, 3, 0, 3, 0, 0, 0};
`endif
        pb = pop_log.size();
        qb = push_log.size();
        load(0, 3, 176);
        load(3, 3, 176);
        wait_push(qb + 6, 30, "t6 six pushes");
        for (int i = 0; i < 6; i++)
            chk($sformatf("t6 pop order %0d", i), pop_at(pb + i), exp_order[i]);

        chk("pop one-hot", multi_pop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_tx_rr.md
Name: arbitro_tx_rr

Overview:
- Transmit-side aggregator for the PCIE transaction path; the mirror of the receive-side demux.
- Drains four per-class source FIFOs (lanes 0-3) through a round-robin arbiter into one 12-bit push stream toward a single downstream FIFO.
- Applies hysteresis flow control against the downstream occupancy using umbral_L/umbral_H, which are latched during init.
- Keeps per-lane word counters, readable with the same req/idx interface the rest of the PCIE path uses.

Parameters:
TAMANO_DATOS, 12, word width on every data port
UMBRALES_L_H, 8, width of umbral_L, umbral_H and ocup_out
CONT_W, 5, width of each per-lane word counter and of cuenta

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
init  in  1  1 = configuration; latch thresholds, no new pops
umbral_L  in  UMBRALES_L_H  resume threshold
umbral_H  in  UMBRALES_L_H  pause threshold
empty_in  in  4  empty flag of source FIFO k on bit k
data_in0..data_in3  in  TAMANO_DATOS each  source FIFO read data; valid the cycle after that lane's pop
pop  out  4  one-hot-or-zero read strobe to source FIFOs
ocup_out  in  UMBRALES_L_H  downstream FIFO occupancy
push_out  out  1  downstream write strobe
data_out  out  TAMANO_DATOS  word written downstream
req  in  1  counter read request
idx  in  3  counter index
cuenta  out  CONT_W  counter read data
valid_cuenta  out  1  cuenta valid

Behaviour:
- Reset (reset=0): pop=0, push_out=0, data_out=0, cuenta=0, valid_cuenta=0; counters=0; rr pointer=3 (lane 0 wins first); pausa=0; umbral regs=0; state=RESET. In-flight words are discarded.
- FSM states: RESET, INIT, IDLE, ACTIVE.
  - RESET -> INIT on the first clock after reset rises.
  - INIT: umbral_L_reg/umbral_H_reg load every cycle while init=1. INIT -> IDLE when init=0.
  - IDLE -> ACTIVE when (empty_in != 4'hF) and pausa=0.
  - ACTIVE -> IDLE when all lanes are empty or pausa=1.
  - Any state -> INIT when init=1.
- pop is combinational and nonzero only in ACTIVE with pausa=0 and init=0.
- Grant rule: grant the first non-empty lane after the rr pointer, wrapping 3 -> 0. The pointer updates only on a grant. Throughput is one word per cycle; back-to-back grants to the same lane are allowed when it is the only non-empty lane.
- Latency: pop[k]=1 in cycle N -> data_ink sampled in N+1 -> push_out=1, data_out=data_ink registered in cycle N+2. Payload passes unmodified.
- Words already popped when init rises or pausa sets still complete their push.
- pausa flag (registered):
  - sets when ocup_out >= umbral_H_reg;
  - clears when ocup_out <= umbral_L_reg;
  - holds otherwise.
  - Up to 3 words may follow a threshold crossing; downstream must size umbral_H with that margin.
  - If umbral_L_reg >= umbral_H_reg, set takes priority.
- Counters:
  - contador[k] increments on each push_out from lane k and wraps 31 -> 0.
  - Counters are not cleared by init.
- Counter read:
  - req=1 in cycle N -> cuenta=contador[idx], valid_cuenta=1 in N+1.
  - idx 4-7 return 0 with valid_cuenta=1.
  - A push on the same edge returns the pre-increment value.
  - valid_cuenta=0 when req was 0.

Optional Feature:
- Macro PRIO_FIJA_EN.
- Defined: fixed priority, lane 0 highest, lane 3 lowest; the rr pointer is removed.
- Undefined: round-robin as described above.
- Pipeline, counters and flow control are identical in both builds.

Decomposition:
- Shared package pcie_tx_pkg: FSM state encoding (RESET=0, INIT=1, IDLE=2, ACTIVE=3), N_LANES=4, lane ID width=2.
- Sub-module rr_arbitro: combinational grant from empty_in and pointer, plus pointer register; the PRIO_FIJA_EN switch lives here.

Test Plan:
- Reset, then init=1 with umbral_L=2, umbral_H=6, then init=0; all lanes filled with 2 words, ocup_out=0 -> pop order 0,1,2,3,0,1,2,3; first push_out 2 cycles after first pop; 8 pushes; counters read 2 each.
- Only lane 2 non-empty with 5 words -> 5 consecutive pops on lane 2; data_out equals the lane 2 words in order.
- ocup_out raised to 6 mid-stream -> pops stop within 1 cycle, at most 3 further pushes; ocup_out=3 -> still paused; ocup_out=2 -> pops resume.
- reset dropped while 2 words are in flight -> push_out=0 immediately, counters=0; lane 0 wins first after release.
- lane 1 pushes 33 words -> contador[1]=1; req=1, idx=5 -> cuenta=0, valid_cuenta=1 next cycle.
- PRIO_FIJA_EN build, lanes 0 and 3 both non-empty -> lane 0 drained completely before the first pop of lane 3.
